// File: rtl/cpu6_decode_stage.sv
// ============================================================================
// Module   : cpu6_decode_stage
// Brief    : Registered RV32I decode stage with 2-entry skid buffer and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu6_decode_stage #(
    parameter int unsigned PC_WIDTH      = 32,
    parameter int unsigned EN_CSR        = 1,
    parameter int unsigned EN_BRANCH_EXT = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [31:0]         out_imm,
    output logic [3:0]          out_aluop,
    output logic                out_alusrc,
    output logic                out_alua_pc,
    output logic [2:0]          out_branchtype,
    output logic [1:0]          out_jump,
    output logic                out_memtoreg,
    output logic                out_memwrite,
    output logic                out_regwrite,
    output logic                out_csr,
    output logic                out_csr_rs1uimm,
    output logic [1:0]          out_csr_wsc,
    output logic                out_illinstr
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic [3:0]          aluop;
        logic                alusrc;
        logic                alua_pc;
        logic [2:0]          branchtype;
        logic [1:0]          jump;
        logic                memtoreg;
        logic                memwrite;
        logic                regwrite;
        logic                csr;
        logic                csr_rs1uimm;
        logic [1:0]          csr_wsc;
        logic                illinstr;
    } bundle_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    bundle_t     dec;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        dec.pc  = in_pc;
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        case (opc)
            OPC_OPIMM: begin
                dec.imm      = imm_i;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                legal        = 1'b1;
                case (f3)
                    3'b000: dec.aluop = ALU_ADD;
                    3'b001: begin
                        dec.aluop = ALU_SLL;
                        legal     = (f7 == F7_BASE);
                    end
                    3'b010: dec.aluop = ALU_SLT;
                    3'b011: dec.aluop = ALU_SLTU;
                    3'b100: dec.aluop = ALU_XOR;
                    3'b101: begin
                        dec.aluop = f7[5] ? ALU_SRA : ALU_SRL;
                        legal     = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    3'b110: dec.aluop = ALU_OR;
                    default: dec.aluop = ALU_AND;
                endcase
            end
            OPC_OP: begin
                dec.regwrite = 1'b1;
                if (f7 == F7_BASE) begin
                    legal = 1'b1;
                    case (f3)
                        3'b000: dec.aluop = ALU_ADD;
                        3'b001: dec.aluop = ALU_SLL;
                        3'b010: dec.aluop = ALU_SLT;
                        3'b011: dec.aluop = ALU_SLTU;
                        3'b100: dec.aluop = ALU_XOR;
                        3'b101: dec.aluop = ALU_SRL;
                        3'b110: dec.aluop = ALU_OR;
                        default: dec.aluop = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    legal     = 1'b1;
                    dec.aluop = f3[2] ? ALU_SRA : ALU_SUB;
                end
            end
            OPC_LOAD: begin
                legal        = (f3 == 3'b010);
                dec.imm      = imm_i;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_STORE: begin
                legal        = (f3 == 3'b010);
                dec.imm      = imm_s;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm   = imm_b;
                dec.aluop = ALU_SUB;
                case (f3)
                    3'b000: begin
                        legal          = 1'b1;
                        dec.branchtype = 3'b001;
                    end
                    3'b001: begin
                        legal          = 1'b1;
                        dec.branchtype = 3'b010;
                    end
                    3'b100, 3'b101, 3'b110, 3'b111: begin
                        legal          = (EN_BRANCH_EXT != 0);
                        dec.branchtype = f3;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                legal        = 1'b1;
                dec.imm      = imm_j;
                dec.jump     = 2'b01;
                dec.regwrite = 1'b1;
                dec.alua_pc  = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OPC_JALR: begin
                legal        = (f3 == 3'b000);
                dec.imm      = imm_i;
                dec.jump     = 2'b10;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OPC_LUI: begin
                legal        = 1'b1;
                dec.imm      = imm_u;
                dec.aluop    = ALU_PASS;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                legal        = 1'b1;
                dec.imm      = imm_u;
                dec.alua_pc  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_SYSTEM: begin
                // funct3 low bits select W/S/C; bit 2 selects the uimm form
                legal           = (EN_CSR != 0) && (f3[1:0] != 2'b00);
                dec.imm         = {20'b0, in_instr[31:20]};
                dec.csr         = 1'b1;
                dec.regwrite    = 1'b1;
                dec.csr_rs1uimm = f3[2];
                dec.csr_wsc     = f3[1:0];
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.imm         = '0;
            dec.aluop       = '0;
            dec.alusrc      = 1'b0;
            dec.alua_pc     = 1'b0;
            dec.branchtype  = '0;
            dec.jump        = '0;
            dec.memtoreg    = 1'b0;
            dec.memwrite    = 1'b0;
            dec.regwrite    = 1'b0;
            dec.csr         = 1'b0;
            dec.csr_rs1uimm = 1'b0;
            dec.csr_wsc     = '0;
            dec.illinstr    = 1'b1;
        end
    end

    bundle_t main_q, main_d, skid_q, skid_d;
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept, pop;

    assign accept = in_valid & in_ready_q & ~flush;
    assign pop    = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = dec;
                end
            end else begin
                main_valid_d = accept;
                skid_valid_d = 1'b0;
                if (accept) begin
                    main_d = dec;
                end
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = main_valid_q;
    assign out_pc          = main_q.pc;
    assign out_rd          = main_q.rd;
    assign out_rs1         = main_q.rs1;
    assign out_rs2         = main_q.rs2;
    assign out_imm         = main_q.imm;
    assign out_aluop       = main_q.aluop;
    assign out_alusrc      = main_q.alusrc;
    assign out_alua_pc     = main_q.alua_pc;
    assign out_branchtype  = main_q.branchtype;
    assign out_jump        = main_q.jump;
    assign out_memtoreg    = main_q.memtoreg;
    assign out_memwrite    = main_q.memwrite;
    assign out_regwrite    = main_q.regwrite;
    assign out_csr         = main_q.csr;
    assign out_csr_rs1uimm = main_q.csr_rs1uimm;
    assign out_csr_wsc     = main_q.csr_wsc;
    assign out_illinstr    = main_q.illinstr;

endmodule

`default_nettype wire

// File: doc/cpu6_decode_stage.md
Name: cpu6_decode_stage

Overview:
Registered RV32I decode stage for the cpu6 pipeline. It sits between fetch and execute. The decoder covers full RV32I integer ops, loads/stores, all six branches, jal/jalr, lui/auipc and optional CSR ops. It generates the sign-extended immediate and register indices, and flags illegal instructions. It has a 2-entry skid buffer with valid/ready handshakes on both sides and a flush input for branch redirect and trap.

Parameters:
PC_WIDTH, 32, width of pc input/output.
EN_CSR, 1, 1: csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci decoded; 0: those opcodes are illegal.
EN_BRANCH_EXT, 1, 1: blt/bge/bltu/bgeu decoded; 0: those are illegal (beq/bne always legal).

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
flush  in  1  discard all held and incoming instructions this cycle.
in_valid  in  1  fetch presents instr/pc.
in_ready  out  1  stage can accept.
in_instr  in  32  instruction word.
in_pc  in  PC_WIDTH  instruction address.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  execute accepts bundle.
out_pc  out  PC_WIDTH  pc of bundle.
out_rd / out_rs1 / out_rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20]).
out_imm  out  32  immediate, sign-extended per type.
out_aluop  out  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 pass-imm.
out_alusrc  out  1  0 rs2, 1 imm.
out_alua_pc  out  1  ALU operand A = pc (auipc, jal).
out_branchtype  out  3  000 none, 001 beq, 010 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
out_jump  out  2  00 none, 01 jal, 10 jalr.
out_memtoreg / out_memwrite / out_regwrite  out  1 each.
out_csr  out  1  CSR op.
out_csr_rs1uimm  out  1  0 rs1, 1 rs1 field as uimm.
out_csr_wsc  out  2  01 W, 10 S, 11 C.
out_illinstr  out  1  illegal encoding; all side-effect controls forced 0.

Behaviour:
- Decode is combinational on in_instr. The result is captured into the main register; latency is 1 cycle from acceptance to out_valid.
- Storage: main entry (drives outputs) plus skid entry. in_ready = ~skid_valid, registered, with no combinational path from out_ready.
- Accept = in_valid & in_ready & ~flush.
- Main empty, or main popped (out_ready) this cycle:
  - main loads the skid entry if skid_valid, else the accepted input.
  - When main loads from skid, an accept in the same cycle goes into skid; otherwise skid clears.
- Main full and not popped: an accept writes skid.
- Order is strictly FIFO. Simultaneous accept+pop with the skid empty keeps throughput at 1/cycle.
- out_* fields are stable while out_valid & ~out_ready.
- flush: next cycle main_valid=0 and skid_valid=0. The input offered in the flush cycle is dropped. flush overrides a same-cycle pop and accept.
- Reset (async assert, sync release): out_valid=0, skid_valid=0, in_ready=1. All out_* data/control fields are 0, so out_branchtype=000 and out_jump=00.
- Immediates:
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All sign-extended from the top bit. R-type and CSR: imm=0 (except CSR imm = zero-extended [31:20] as CSR address).
- Shift-immediate: slli/srli require instr[31:25]=0000000; srai requires 0100000; anything else is illegal. R-type funct7 must be 0000000, or 0100000 for sub/sra only.
- Loads: only lw (funct3=010) and stores: only sw (funct3=010) are legal; other widths are illegal.
- lui: aluop=10, alusrc=1. auipc: aluop=0, alua_pc=1, alusrc=1.
- jal/jalr: regwrite=1, aluop=add.
- Branches: aluop=sub, alusrc=0, regwrite=0.
- Any illegal instruction: illinstr=1, while regwrite, memwrite, memtoreg, csr, branchtype and jump are all 0. The bundle is still delivered in order.
- All-zero instruction is illegal.

Test Plan:
- Reset with resetn=0 mid-stream -> next edge out_valid=0, in_ready=1; all bundle fields 0.
- 0x00500093 (addi x1,x0,5), out_ready=1 -> one cycle later out_valid=1, rd=1, rs1=0, imm=5, aluop=0, alusrc=1, regwrite=1, illinstr=0.
- 0x402081B3 (sub x3,x1,x2) then 0xFE20CCE3 (blt x1,x2,-8) back-to-back -> aluop=1, rd=3 on first; on second branchtype=100, imm=0xFFFFFFF8, regwrite=0. With EN_BRANCH_EXT=0 the second gives illinstr=1, branchtype=000.
- 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, aluop=10, rd=5. Then 0x00000000 -> illinstr=1, regwrite=0, memwrite=0.
- Backpressure: hold out_ready=0 and offer 3 instructions -> 2 accepted, in_ready=0 after the second. Release out_ready -> delivered in order, 1/cycle, with no loss or duplication.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the offered instruction is never output.
